uart_tx_frame_ctrl: RTL and testbench
=====================================

// Module: uart_tx_frame_ctrl
// PURPOSE
//  UART transmit framer and serializer, directly downstream of the parity calculator.
//  - Accepts a parallel word and shifts out one frame, LSB first, one bit per clk:
//    start(0) -> data_width data bits -> optional parity -> stop(1).
//  - The parity bit is taken from the parity calculator's registered par_bit output.
//  - clk is the prescaled baud-rate clock; the serial line idles high.
// PARAMETERS
//  data_width  8  payload bits per frame (>=2); bit counter is $clog2(data_width) bits wide
// PORTS
//  clk         in   1           baud clock, rising-edge
//  rst         in   1           asynchronous, active-low reset
//  P_DATA      in   data_width  payload word, sampled on accept
//  Data_Valid  in   1           request to send P_DATA (single-cycle strobe)
//  PAR_EN      in   1           1 = insert parity bit, sampled on accept
//  par_bit     in   1           parity bit from the parity calculator (same P_DATA/Data_Valid)
//  TX_OUT      out  1           serial line, registered
//  busy        out  1           frame in progress, registered
// BEHAVIOUR
//  - Reset (async, rst=0): state IDLE, TX_OUT=1, busy=0, shift reg=0, bit count=0, par_en_q=0.
//    Asserting reset mid-frame aborts the frame immediately; no partial bits are emitted afterwards.
//  - All outputs are registered; no combinational path from any input to TX_OUT or busy.
//  - Accept happens on a rising edge where state==IDLE and Data_Valid=1.
//    - Latch P_DATA into the shift register and PAR_EN into par_en_q.
//    - Next state is START; TX_OUT<=0; busy<=1.
//  - Data_Valid in any state other than IDLE is ignored; the word is dropped.
//    - Integration rule: Data_Valid drives both this block and the parity calculator.
//    - The source therefore asserts Data_Valid only while busy=0.
//  - FSM states and transitions (one clk per state visit, except DATA):
//    - IDLE: TX_OUT=1, busy=0. Go to START on accept, else stay.
//    - START: line already 0. Next edge: TX_OUT<=shift[0], cnt<=0, go to DATA.
//    - DATA: shift right each edge, cnt++.
//      - cnt==data_width-1 and par_en_q=1: TX_OUT<=par_bit, go to PARITY.
//      - cnt==data_width-1 and par_en_q=0: TX_OUT<=1, go to STOP.
//    - PARITY: next edge TX_OUT<=1, go to STOP.
//    - STOP: next edge go to IDLE, busy<=0, TX_OUT stays 1.
//  - par_bit timing: par_bit is valid 2 clks after accept, and it is sampled data_width+1 clks
//    after accept. This margin is safe for data_width>=2.
//    - PAR_TYP must stay stable from accept until the PARITY state ends.
//  - Frame length on the line: 1+data_width+PAR_EN+1 clks.
//    - busy is high from the edge after accept through the stop bit.
//    - Minimum spacing between start bits: frame length + 1 clk (one IDLE cycle).
//  - P_DATA and PAR_EN changes after accept do not affect the frame in flight.
// TESTING
//  1. Reset: hold rst=0 -> TX_OUT=1, busy=0; release rst, no Data_Valid -> TX_OUT stays 1.
//  2. P_DATA=8'hA5, PAR_EN=1, PAR_TYP=0 (even) -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,0(par),1.
//     busy is high for exactly 11 clks.
//  3. P_DATA=8'h01, PAR_EN=0 -> TX_OUT sequence 0,1,0,0,0,0,0,0,0,1.
//     busy is high for 10 clks, then drops.
//  4. Pulse Data_Valid with P_DATA=8'hFF mid-frame (while busy) -> current frame bits unchanged.
//     The 8'hFF word is never sent.
//  5. Pull rst=0 during data bit 4 -> TX_OUT=1, busy=0 asynchronously.
//     After release, the next accept sends a complete, correct frame.
//  6. Back-to-back: hold Data_Valid=1 continuously with 8'h3C then 8'hC3 -> second start bit
//     begins exactly one IDLE clk after the first stop bit. Both frames carry correct odd
//     parity (PAR_TYP=1).

Source files
------------

// File: rtl/uart_tx_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_frame_ctrl
// Description : UART transmit framer/serializer. Accepts a parallel word on a
//               Data_Valid strobe and shifts out one frame, LSB first, one bit
//               per baud clock:
//                   start(0) -> DATA_WIDTH data bits -> [parity] -> stop(1)
//               The parity bit comes from the upstream parity calculator's
//               registered par_bit output. The line idles high.
// Ports       : clk        in  1           baud clock, rising edge
//               rst        in  1           asynchronous, active-low reset
//               P_DATA     in  DATA_WIDTH  payload word, sampled on accept
//               Data_Valid in  1           send request (ignored unless idle)
//               PAR_EN     in  1           insert parity bit, sampled on accept
//               par_bit    in  1           parity bit from parity calculator
//               TX_OUT     out 1           serial line, registered
//               busy       out 1           frame in progress, registered
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_frame_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  par_bit,
    output logic                  TX_OUT,
    output logic                  busy
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                  state_q;
    logic [DATA_WIDTH-1:0]   shift_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    par_en_q;

    // Single registered FSM: every output is assigned here, so nothing on the
    // input side can reach TX_OUT or busy combinationally. TX_OUT is always
    // loaded with the value the line must carry during the *next* clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            shift_q  <= '0;
            cnt_q    <= '0;
            par_en_q <= 1'b0;
            TX_OUT   <= 1'b1;
            busy     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    TX_OUT <= 1'b1;
                    busy   <= 1'b0;
                    if (Data_Valid) begin
                        shift_q  <= P_DATA;
                        par_en_q <= PAR_EN;
                        TX_OUT   <= 1'b0;       // start bit
                        busy     <= 1'b1;
                        state_q  <= S_START;
                    end
                end

                S_START: begin
                    TX_OUT  <= shift_q[0];      // data bit 0
                    shift_q <= shift_q >> 1;
                    cnt_q   <= '0;
                    state_q <= S_DATA;
                end

                // cnt_q counts data bits already placed on the line minus one;
                // when it reaches the last index the final data bit has just
                // been shown and the trailer bit is loaded instead.
                S_DATA: begin
                    if (cnt_q == c_cnt_last) begin
                        if (par_en_q) begin
                            TX_OUT  <= par_bit;
                            state_q <= S_PARITY;
                        end else begin
                            TX_OUT  <= 1'b1;
                            state_q <= S_STOP;
                        end
                    end else begin
                        TX_OUT  <= shift_q[0];
                        shift_q <= shift_q >> 1;
                        cnt_q   <= cnt_q + 1'b1;
                    end
                end

                S_PARITY: begin
                    TX_OUT  <= 1'b1;            // stop bit
                    state_q <= S_STOP;
                end

                S_STOP: begin
                    TX_OUT  <= 1'b1;
                    busy    <= 1'b0;
                    state_q <= S_IDLE;
                end

                default: begin
                    TX_OUT  <= 1'b1;
                    busy    <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_frame_ctrl
// Description : Self-checking bench for uart_tx_frame_ctrl. Expected line
//               contents are built from the frame format (start, data LSB
//               first, optional parity, stop) and compared bit by bit. A small
//               parity-calculator model supplies par_bit two clocks after the
//               Data_Valid strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_frame_ctrl;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] pdata;
    logic          dv;
    logic          pen;
    logic          pbit;
    logic          ptyp;
    logic          tx;
    logic          bsy;

    int checks = 0;
    int errors = 0;

    bit exp_q[$];
    bit line_a[64];
    bit busy_a[64];

    always #5 clk = ~clk;

    uart_tx_frame_ctrl #(.DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .P_DATA     (pdata),
        .Data_Valid (dv),
        .PAR_EN     (pen),
        .par_bit    (pbit),
        .TX_OUT     (tx),
        .busy       (bsy)
    );

    // Parity calculator stand-in: latches the word on Data_Valid, registers
    // parity one clock later (valid two clocks after the strobe).
    logic [DW-1:0] pc_data;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_data <= '0;
            pbit    <= 1'b0;
        end else begin
            if (dv) pc_data <= pdata;
            pbit <= (^pc_data) ^ ptyp;
        end
    end

    // Expected frame on the line, one entry per baud clock.
    function automatic void build(input logic [DW-1:0] d, input logic pe, input logic pt);
        exp_q.delete();
        exp_q.push_back(1'b0);
        for (int i = 0; i < DW; i++) exp_q.push_back(d[i]);
        if (pe) exp_q.push_back((^d) ^ pt);
        exp_q.push_back(1'b1);
    endfunction

    // Strobe Data_Valid for one clock; returns at the negedge after accept,
    // where the start bit should be on the line.
    task automatic send(input logic [DW-1:0] d, input logic pe);
        @(negedge clk);
        pdata = d;
        pen   = pe;
        dv    = 1'b1;
        @(negedge clk);
        dv    = 1'b0;
    endtask

    // Record the line for n clocks. inj >= 0 pulses Data_Valid with 8'hFF at
    // that index; scr scrambles P_DATA/PAR_EN after accept.
    task automatic capture(input int n, input int inj, input bit scr);
        for (int i = 0; i < n; i++) begin
            line_a[i] = tx;
            busy_a[i] = bsy;
            if (i == inj) begin
                dv    = 1'b1;
                pdata = 8'hFF;
            end else begin
                dv = 1'b0;
            end
            if (scr) begin
                pdata = DW'($urandom);
                pen   = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b0; dv = 1'b0; pen = 1'b0; pdata = '0; ptyp = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (tx !== 1'b1 || bsy !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: TX_OUT=%b busy=%b, required 1/0", tx, bsy);
        end
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (tx !== 1'b1 || bsy !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle[%0d]: TX_OUT=%b busy=%b, required 1/0", i, tx, bsy);
            end
        end
    endtask

    task automatic test_parity_a5;
        int ones;
        ptyp = 1'b0;
        build(8'hA5, 1'b1, 1'b0);
        send(8'hA5, 1'b1);
        capture(14, -1, 1'b0);
        ones = 0;
        for (int i = 0; i < 14; i++) begin
            bit e;
            e = (i < exp_q.size()) ? exp_q[i] : 1'b1;
            checks++;
            if (line_a[i] !== e) begin
                errors++;
                $display("FAIL a5_bit[%0d]: TX_OUT=%b, required %b", i, line_a[i], e);
            end
            ones += int'(busy_a[i]);
        end
        checks++;
        if (ones != 11 || busy_a[10] !== 1'b1 || busy_a[11] !== 1'b0) begin
            errors++;
            $display("FAIL a5_busy: busy clks=%0d, required 11", ones);
        end
    endtask

    task automatic test_noparity_01;
        build(8'h01, 1'b0, 1'b0);
        send(8'h01, 1'b0);
        capture(13, -1, 1'b0);
        for (int i = 0; i < 13; i++) begin
            bit e, eb;
            e  = (i < exp_q.size()) ? exp_q[i] : 1'b1;
            eb = (i < 10);
            checks++;
            if (line_a[i] !== e || busy_a[i] !== eb) begin
                errors++;
                $display("FAIL np01[%0d]: TX_OUT=%b busy=%b, required %b/%b",
                         i, line_a[i], busy_a[i], e, eb);
            end
        end
    endtask

    task automatic test_ignore_midframe;
        build(8'h96, 1'b0, 1'b0);
        send(8'h96, 1'b0);
        capture(16, 4, 1'b0);
        for (int i = 0; i < 16; i++) begin
            bit e, eb;
            e  = (i < exp_q.size()) ? exp_q[i] : 1'b1;
            eb = (i < 10);
            checks++;
            if (line_a[i] !== e || busy_a[i] !== eb) begin
                errors++;
                $display("FAIL ignore[%0d]: TX_OUT=%b busy=%b, required %b/%b",
                         i, line_a[i], busy_a[i], e, eb);
            end
        end
    endtask

    task automatic test_reset_midframe;
        logic [DW-1:0] d;
        ptyp = 1'b0;
        send(8'hA5, 1'b1);
        repeat (5) @(negedge clk);          // line now carries data bit 4
        rst = 1'b0;
        #1;
        checks++;
        if (tx !== 1'b1 || bsy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_async: TX_OUT=%b busy=%b, required 1/0", tx, bsy);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (tx !== 1'b1 || bsy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_hold: TX_OUT=%b busy=%b, required 1/0", tx, bsy);
        end
        rst = 1'b1;
        @(negedge clk);
        d = DW'($urandom);
        build(d, 1'b1, 1'b0);
        send(d, 1'b1);
        capture(13, -1, 1'b0);
        for (int i = 0; i < 13; i++) begin
            bit e, eb;
            e  = (i < exp_q.size()) ? exp_q[i] : 1'b1;
            eb = (i < exp_q.size());
            checks++;
            if (line_a[i] !== e || busy_a[i] !== eb) begin
                errors++;
                $display("FAIL rst_after[%0d]: TX_OUT=%b busy=%b, required %b/%b",
                         i, line_a[i], busy_a[i], e, eb);
            end
        end
    endtask

    task automatic test_back_to_back;
        bit e[28];
        bit eb[28];
        for (int i = 0; i < 28; i++) begin e[i] = 1'b1; eb[i] = 1'b0; end
        ptyp = 1'b1;
        build(8'h3C, 1'b1, 1'b1);
        for (int i = 0; i < exp_q.size(); i++) begin e[i] = exp_q[i]; eb[i] = 1'b1; end
        build(8'hC3, 1'b1, 1'b1);
        for (int i = 0; i < exp_q.size(); i++) begin e[12+i] = exp_q[i]; eb[12+i] = 1'b1; end
        @(negedge clk);
        pdata = 8'h3C; pen = 1'b1; dv = 1'b1;
        @(negedge clk);
        pdata = 8'hC3;                      // Data_Valid stays high
        for (int i = 0; i < 28; i++) begin
            line_a[i] = tx;
            busy_a[i] = bsy;
            if (i == 12) dv = 1'b0;
            @(negedge clk);
        end
        for (int i = 0; i < 28; i++) begin
            checks++;
            if (line_a[i] !== e[i] || busy_a[i] !== eb[i]) begin
                errors++;
                $display("FAIL b2b[%0d]: TX_OUT=%b busy=%b, required %b/%b",
                         i, line_a[i], busy_a[i], e[i], eb[i]);
            end
        end
    endtask

    task automatic test_random;
        for (int f = 0; f < 20; f++) begin
            logic [DW-1:0] d;
            logic          pe;
            int            n;
            d    = DW'($urandom);
            pe   = 1'($urandom_range(0, 1));
            ptyp = 1'($urandom_range(0, 1));
            build(d, pe, ptyp);
            n = exp_q.size() + 2;
            send(d, pe);
            capture(n, -1, 1'b1);
            for (int i = 0; i < n; i++) begin
                bit e, eb;
                e  = (i < exp_q.size()) ? exp_q[i] : 1'b1;
                eb = (i < exp_q.size());
                checks++;
                if (line_a[i] !== e || busy_a[i] !== eb) begin
                    errors++;
                    $display("FAIL rand%0d[%0d] d=%h pe=%b pt=%b: TX_OUT=%b busy=%b, required %b/%b",
                             f, i, d, pe, ptyp, line_a[i], busy_a[i], e, eb);
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_parity_a5;
        test_noparity_01;
        test_ignore_midframe;
        test_reset_midframe;
        test_back_to_back;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
